// File: rtl/prefetcher_arb_pkg.sv
// Shared types and reset constants for the prefetcher slice arbiter.
package prefetcher_arb_pkg;

    localparam int DEF_NUM_SLICES = 4;
    localparam int DEF_ADDR_BITS  = 64;
    localparam int DEF_LEN_WIDTH  = 8;
    localparam int DEF_TID_WIDTH  = 8;

    typedef logic [$clog2(DEF_NUM_SLICES)-1:0] slice_idx_t;

    typedef struct packed {
        logic [DEF_ADDR_BITS-1:0] addr;
        logic [DEF_LEN_WIDTH-1:0] len;
        logic [DEF_TID_WIDTH-1:0] id;
    } ar_req_t;

    // last_grant resets to the highest index so slice 0 wins the first scan.
    localparam slice_idx_t FIRST_PRIO_RESET = slice_idx_t'(DEF_NUM_SLICES - 1);

    function automatic int first_prio_reset(input int n);
        return n - 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester after last_grant, wrapping.
module rr_arbiter #(
    parameter int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last_grant,
    output logic [N-1:0] grant_oh,
    output logic [W-1:0] grant_idx,
    output logic         any_grant
);

    always_comb begin
        int idx;
        grant_oh  = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        idx       = 0;
        for (int off = 1; off <= N; off++) begin
            idx = (int'(last_grant) + off) % N;
            if (!any_grant && req[idx]) begin
                any_grant     = 1'b1;
                grant_oh[idx] = 1'b1;
                grant_idx     = W'(idx);
            end
        end
    end

endmodule

// File: rtl/prefetcher_slice_arbiter.sv
// Shares one AXI AR/R channel pair among the prefetcher slices: round-robin AR
// into a one-entry register stage, R beats steered by learned context TID.
module prefetcher_slice_arbiter
    import prefetcher_arb_pkg::*;
#(
    parameter int NUM_SLICES      = DEF_NUM_SLICES,
    parameter int ADDR_BITS       = DEF_ADDR_BITS,
    parameter int BURST_LEN_WIDTH = DEF_LEN_WIDTH,
    parameter int TID_WIDTH       = DEF_TID_WIDTH,
    localparam int SLICE_IDX_W    = $clog2(NUM_SLICES)
) (
    input  logic                                  clk,
    input  logic                                  resetN,
    input  logic                                  en,
    input  logic [NUM_SLICES-1:0]                 sl_ar_valid,
    output logic [NUM_SLICES-1:0]                 sl_ar_ready,
    input  logic [NUM_SLICES*ADDR_BITS-1:0]       sl_ar_addr,
    input  logic [NUM_SLICES*BURST_LEN_WIDTH-1:0] sl_ar_len,
    input  logic [NUM_SLICES*TID_WIDTH-1:0]       sl_ar_id,
    output logic                                  m_ar_valid,
    input  logic                                  m_ar_ready,
    output logic [ADDR_BITS-1:0]                  m_ar_addr,
    output logic [BURST_LEN_WIDTH-1:0]            m_ar_len,
    output logic [TID_WIDTH-1:0]                  m_ar_id,
    input  logic [NUM_SLICES-1:0]                 sl_ctx_valid,
    input  logic [NUM_SLICES*TID_WIDTH-1:0]       sl_ctx_id,
    input  logic                                  m_r_valid,
    output logic                                  m_r_ready,
    input  logic [TID_WIDTH-1:0]                  m_r_id,
    output logic [NUM_SLICES-1:0]                 sl_r_valid,
    input  logic [NUM_SLICES-1:0]                 sl_r_ready,
    output logic                                  r_unmatched,
    output logic [SLICE_IDX_W-1:0]                last_grant
);

    localparam logic [SLICE_IDX_W-1:0] LAST_GRANT_RST =
        SLICE_IDX_W'(first_prio_reset(NUM_SLICES));

    logic                       m_ar_valid_q, m_ar_valid_d;
    logic [ADDR_BITS-1:0]       m_ar_addr_q,  m_ar_addr_d;
    logic [BURST_LEN_WIDTH-1:0] m_ar_len_q,   m_ar_len_d;
    logic [TID_WIDTH-1:0]       m_ar_id_q,    m_ar_id_d;
    logic [SLICE_IDX_W-1:0]     last_grant_q, last_grant_d;

    logic [NUM_SLICES-1:0]  grant_oh;
    logic [SLICE_IDX_W-1:0] grant_idx;
    logic                   any_grant;
    logic                   cap;

    rr_arbiter #(.N(NUM_SLICES)) u_rr (
        .req        (sl_ar_valid),
        .last_grant (last_grant_q),
        .grant_oh   (grant_oh),
        .grant_idx  (grant_idx),
        .any_grant  (any_grant)
    );

    // The stage accepts a new request when empty or when its content leaves this cycle.
    assign cap         = en & (~m_ar_valid_q | m_ar_ready);
    assign sl_ar_ready = cap ? grant_oh : '0;

    always_comb begin
        m_ar_valid_d = m_ar_valid_q;
        m_ar_addr_d  = m_ar_addr_q;
        m_ar_len_d   = m_ar_len_q;
        m_ar_id_d    = m_ar_id_q;
        last_grant_d = last_grant_q;
        if (cap) begin
            m_ar_valid_d = any_grant;
            if (any_grant) begin
                m_ar_addr_d  = sl_ar_addr[grant_idx*ADDR_BITS +: ADDR_BITS];
                m_ar_len_d   = sl_ar_len[grant_idx*BURST_LEN_WIDTH +: BURST_LEN_WIDTH];
                m_ar_id_d    = sl_ar_id[grant_idx*TID_WIDTH +: TID_WIDTH];
                last_grant_d = grant_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            m_ar_valid_q <= 1'b0;
            m_ar_addr_q  <= '0;
            m_ar_len_q   <= '0;
            m_ar_id_q    <= '0;
            last_grant_q <= LAST_GRANT_RST;
        end else begin
            m_ar_valid_q <= m_ar_valid_d;
            m_ar_addr_q  <= m_ar_addr_d;
            m_ar_len_q   <= m_ar_len_d;
            m_ar_id_q    <= m_ar_id_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign m_ar_valid = m_ar_valid_q;
    assign m_ar_addr  = m_ar_addr_q;
    assign m_ar_len   = m_ar_len_q;
    assign m_ar_id    = m_ar_id_q;
    assign last_grant = last_grant_q;

    logic [NUM_SLICES-1:0] match;
    logic [NUM_SLICES-1:0] sel;

    for (genvar gi = 0; gi < NUM_SLICES; gi++) begin : g_match
        assign match[gi] = sl_ctx_valid[gi] & (sl_ctx_id[gi*TID_WIDTH +: TID_WIDTH] == m_r_id);
    end

    // Isolate the lowest set bit so duplicate TIDs resolve to the lowest slice.
    assign sel         = match & (~match + NUM_SLICES'(1));
    assign sl_r_valid  = {NUM_SLICES{m_r_valid}} & sel;
    assign m_r_ready   = |(sel & sl_r_ready);
    assign r_unmatched = m_r_valid & ~(|match);

endmodule

// File: tb/tb_prefetcher_slice_arbiter.sv
// Directed-vector bench for prefetcher_slice_arbiter with hand-computed expectations.
module tb_prefetcher_slice_arbiter;

    logic         clk = 1'b0;
    logic         resetN;
    logic         en;
    logic [3:0]   sl_ar_valid;
    logic [3:0]   sl_ar_ready;
    logic [255:0] sl_ar_addr;
    logic [31:0]  sl_ar_len;
    logic [31:0]  sl_ar_id;
    logic         m_ar_valid;
    logic         m_ar_ready;
    logic [63:0]  m_ar_addr;
    logic [7:0]   m_ar_len;
    logic [7:0]   m_ar_id;
    logic [3:0]   sl_ctx_valid;
    logic [31:0]  sl_ctx_id;
    logic         m_r_valid;
    logic         m_r_ready;
    logic [7:0]   m_r_id;
    logic [3:0]   sl_r_valid;
    logic [3:0]   sl_r_ready;
    logic         r_unmatched;
    logic [1:0]   last_grant;

    logic [63:0] addr_arr [4];
    logic [7:0]  len_arr  [4];
    logic [7:0]  id_arr   [4];
    logic [7:0]  ctx_arr  [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        sl_ar_addr = '0;
        sl_ar_len  = '0;
        sl_ar_id   = '0;
        sl_ctx_id  = '0;
        for (int k = 0; k < 4; k++) begin
            sl_ar_addr[k*64 +: 64] = addr_arr[k];
            sl_ar_len[k*8 +: 8]    = len_arr[k];
            sl_ar_id[k*8 +: 8]     = id_arr[k];
            sl_ctx_id[k*8 +: 8]    = ctx_arr[k];
        end
    end

    prefetcher_slice_arbiter dut (
        .clk          (clk),
        .resetN       (resetN),
        .en           (en),
        .sl_ar_valid  (sl_ar_valid),
        .sl_ar_ready  (sl_ar_ready),
        .sl_ar_addr   (sl_ar_addr),
        .sl_ar_len    (sl_ar_len),
        .sl_ar_id     (sl_ar_id),
        .m_ar_valid   (m_ar_valid),
        .m_ar_ready   (m_ar_ready),
        .m_ar_addr    (m_ar_addr),
        .m_ar_len     (m_ar_len),
        .m_ar_id      (m_ar_id),
        .sl_ctx_valid (sl_ctx_valid),
        .sl_ctx_id    (sl_ctx_id),
        .m_r_valid    (m_r_valid),
        .m_r_ready    (m_r_ready),
        .m_r_id       (m_r_id),
        .sl_r_valid   (sl_r_valid),
        .sl_r_ready   (sl_r_ready),
        .r_unmatched  (r_unmatched),
        .last_grant   (last_grant)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s = %0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected grant order for the all-requesting burst and its slice address.
    int          rr_order [5] = '{0, 1, 2, 3, 0};
    logic [63:0] rr_addr  [5] = '{64'h100, 64'h200, 64'h300, 64'h400, 64'h100};

    initial begin
        resetN       = 1'b0;
        en           = 1'b1;
        sl_ar_valid  = 4'b0000;
        m_ar_ready   = 1'b0;
        sl_ctx_valid = 4'b0000;
        m_r_valid    = 1'b0;
        m_r_id       = 8'h00;
        sl_r_ready   = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            addr_arr[k] = 64'h100 * (k + 1);
            len_arr[k]  = 8'(k);
            id_arr[k]   = 8'h10 + 8'(k);
            ctx_arr[k]  = 8'h00;
        end
        addr_arr[2] = 64'h1000;
        len_arr[2]  = 8'd3;
        id_arr[2]   = 8'd5;

        tick();
        tick();
        check_eq("rst_m_ar_valid", 64'(m_ar_valid), 64'd0);
        check_eq("rst_m_ar_addr", m_ar_addr, 64'd0);
        check_eq("rst_last_grant", 64'(last_grant), 64'd3);
        resetN = 1'b1;
        tick();

        // Single requester: slice 2
        sl_ar_valid = 4'b0100;
        #1;
        check_eq("single_ready", 64'(sl_ar_ready), 64'b0100);
        tick();
        sl_ar_valid = 4'b0000;
        check_eq("single_valid", 64'(m_ar_valid), 64'd1);
        check_eq("single_addr", m_ar_addr, 64'h1000);
        check_eq("single_len", 64'(m_ar_len), 64'd3);
        check_eq("single_id", 64'(m_ar_id), 64'd5);
        check_eq("single_last", 64'(last_grant), 64'd2);

        // Drain with no requester
        m_ar_ready = 1'b1;
        tick();
        check_eq("drain_valid", 64'(m_ar_valid), 64'd0);
        check_eq("drain_last", 64'(last_grant), 64'd2);

        // Fresh reset so the burst starts from slice 0
        resetN = 1'b0;
        #1;
        resetN = 1'b1;
        addr_arr[2] = 64'h300;
        len_arr[2]  = 8'd2;
        id_arr[2]   = 8'h12;
        tick();

        // All four request, master always ready: 0,1,2,3,0 back to back
        sl_ar_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq($sformatf("rr_ready_%0d", i), 64'(sl_ar_ready), 64'(4'b0001 << rr_order[i]));
            tick();
            check_eq($sformatf("rr_valid_%0d", i), 64'(m_ar_valid), 64'd1);
            check_eq($sformatf("rr_addr_%0d", i), m_ar_addr, rr_addr[i]);
            check_eq($sformatf("rr_last_%0d", i), 64'(last_grant), 64'(rr_order[i]));
        end

        // Backpressure: slice 0 held in the stage, slices 1..3 waiting
        m_ar_ready  = 1'b0;
        sl_ar_valid = 4'b1110;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq($sformatf("hold_ready_%0d", i), 64'(sl_ar_ready), 64'd0);
            tick();
            check_eq($sformatf("hold_addr_%0d", i), m_ar_addr, 64'h100);
            check_eq($sformatf("hold_valid_%0d", i), 64'(m_ar_valid), 64'd1);
        end
        m_ar_ready = 1'b1;
        #1;
        check_eq("release_ready", 64'(sl_ar_ready), 64'b0010);
        tick();
        check_eq("release_addr", m_ar_addr, 64'h200);
        check_eq("release_last", 64'(last_grant), 64'd1);

        // en=0 freezes the stage even though the master is ready
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq($sformatf("en0_ready_%0d", i), 64'(sl_ar_ready), 64'd0);
            tick();
            check_eq($sformatf("en0_valid_%0d", i), 64'(m_ar_valid), 64'd1);
            check_eq($sformatf("en0_addr_%0d", i), m_ar_addr, 64'h200);
        end
        check_eq("en0_last", 64'(last_grant), 64'd1);
        en = 1'b1;
        #1;
        check_eq("en1_ready", 64'(sl_ar_ready), 64'b0100);
        tick();
        check_eq("en1_addr", m_ar_addr, 64'h300);
        check_eq("en1_last", 64'(last_grant), 64'd2);

        // R steering, exercised with en low to show it is independent
        en           = 1'b0;
        ctx_arr[0]   = 8'd7;
        ctx_arr[1]   = 8'd9;
        ctx_arr[2]   = 8'd9;
        ctx_arr[3]   = 8'd3;
        sl_ctx_valid = 4'b1111;
        m_r_valid    = 1'b1;
        m_r_id       = 8'd9;
        sl_r_ready   = 4'b0010;
        #1;
        check_eq("r_valid_id9", 64'(sl_r_valid), 64'b0010);
        check_eq("r_ready_id9", 64'(m_r_ready), 64'd1);
        check_eq("r_unm_id9", 64'(r_unmatched), 64'd0);
        sl_r_ready = 4'b0100;
        #1;
        check_eq("r_ready_other", 64'(m_r_ready), 64'd0);
        m_r_id     = 8'd3;
        sl_r_ready = 4'b1000;
        #1;
        check_eq("r_valid_id3", 64'(sl_r_valid), 64'b1000);
        check_eq("r_ready_id3", 64'(m_r_ready), 64'd1);
        m_r_id     = 8'd4;
        sl_r_ready = 4'b1111;
        #1;
        check_eq("r_unm_id4", 64'(r_unmatched), 64'd1);
        check_eq("r_ready_id4", 64'(m_r_ready), 64'd0);
        check_eq("r_valid_id4", 64'(sl_r_valid), 64'd0);
        m_r_valid = 1'b0;
        #1;
        check_eq("r_unm_idle", 64'(r_unmatched), 64'd0);

        // Reset pulse during a hold drops the pending request
        en          = 1'b1;
        m_ar_ready  = 1'b0;
        sl_ar_valid = 4'b1110;
        tick();
        check_eq("prehold_valid", 64'(m_ar_valid), 64'd1);
        #2;
        resetN = 1'b0;
        #1;
        check_eq("arst_valid", 64'(m_ar_valid), 64'd0);
        check_eq("arst_last", 64'(last_grant), 64'd3);
        resetN      = 1'b1;
        sl_ar_valid = 4'b1111;
        #1;
        check_eq("arst_first_ready", 64'(sl_ar_ready), 64'b0001);
        tick();
        check_eq("arst_first_addr", m_ar_addr, 64'h100);
        check_eq("arst_first_last", 64'(last_grant), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
